// File: rtl/eth_phy_10g_pkg.sv
// rtl/eth_phy_10g_pkg.sv - shared constants and types for the 10GBASE-R RX descrambler and BER monitor
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam int DESCR_STATE_W = 58;
    localparam int DESCR_TAP_0   = 38;
    localparam int DESCR_TAP_1   = 57;

    typedef enum logic [1:0] {
        BER_IDLE  = 2'd0,
        BER_COUNT = 2'd1,
        BER_HIGH  = 2'd2
    } ber_state_t;

    function automatic logic sync_hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_descrambler.sv
// rtl/eth_phy_10g_descrambler.sv - self-synchronous x^58 + x^39 + 1 descrambler, one 64-bit block per cycle
module eth_phy_10g_descrambler
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int SCRAMBLER_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DESCR_STATE_W-1:0] state_q;
    logic [DESCR_STATE_W-1:0] state_d;
    logic [DESCR_STATE_W-1:0] lfsr;
    logic [DATA_WIDTH-1:0]    descr;

    // Bit 0 is first on the wire; the received (scrambled) bit feeds the state.
    always_comb begin
        lfsr  = state_q;
        descr = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            descr[i] = i_data[i] ^ lfsr[DESCR_TAP_0] ^ lfsr[DESCR_TAP_1];
            lfsr     = {lfsr[DESCR_STATE_W-2:0], i_data[i]};
        end
        state_d = lfsr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_data = (SCRAMBLER_BYPASS != 0) ? i_data : descr;

endmodule

// File: rtl/eth_phy_10g_rx_descrambler_ber.sv
// rtl/eth_phy_10g_rx_descrambler_ber.sv - RX descrambler plus clause 49 BER monitor producing hi_ber and rx_status
module eth_phy_10g_rx_descrambler_ber
    import eth_phy_10g_pkg::*;
#(
    parameter int HDR_WIDTH        = 2,
    parameter int DATA_WIDTH       = 64,
    parameter int COUNT_125US      = 19531,
    parameter int BER_LIMIT        = 16,
    parameter int SCRAMBLER_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr,
    input  logic [DATA_WIDTH-1:0] i_serdes_rx_data,
    input  logic                  i_rx_block_lock,
    output logic [HDR_WIDTH-1:0]  o_rx_hdr,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_high_ber,
    output logic                  o_rx_status
);

    localparam int TIMER_W = $clog2(COUNT_125US);
    localparam int COUNT_W = $clog2(BER_LIMIT + 1);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(COUNT_125US - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(BER_LIMIT);

    logic [DATA_WIDTH-1:0] descr_data;
    logic [HDR_WIDTH-1:0]  hdr_q;
    logic [DATA_WIDTH-1:0] data_q;
    ber_state_t            state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    count_inc;
    logic                  hi_ber_q, hi_ber_d;
    logic                  status_q, status_d;
    logic                  window_end;

    eth_phy_10g_descrambler #(
        .DATA_WIDTH       (DATA_WIDTH),
        .SCRAMBLER_BYPASS (SCRAMBLER_BYPASS)
    ) u_descrambler (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_serdes_rx_data),
        .o_data (descr_data)
    );

    assign count_inc  = (!sync_hdr_valid(i_serdes_rx_hdr) && count_q != COUNT_MAX)
                      ? count_q + COUNT_W'(1) : count_q;
    assign window_end = (timer_q == TIMER_END);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        hi_ber_d = hi_ber_q;
        if (!i_rx_block_lock) begin
            state_d  = BER_IDLE;
            timer_d  = '0;
            count_d  = '0;
            hi_ber_d = 1'b0;
        end else if (window_end) begin
            // The window-end header is counted before deciding whether hi_ber survives.
            timer_d = '0;
            count_d = '0;
            if (count_inc == COUNT_MAX) begin
                hi_ber_d = 1'b1;
                state_d  = BER_HIGH;
            end else begin
                hi_ber_d = 1'b0;
                state_d  = BER_COUNT;
            end
        end else begin
            timer_d = timer_q + TIMER_W'(1);
            count_d = count_inc;
            case (state_q)
                BER_IDLE, BER_COUNT: begin
                    state_d = BER_COUNT;
                    if (count_inc == COUNT_MAX) begin
                        hi_ber_d = 1'b1;
                        state_d  = BER_HIGH;
                    end
                end
                BER_HIGH: state_d = BER_HIGH;
                default:  state_d = BER_IDLE;
            endcase
        end
        status_d = i_rx_block_lock & ~hi_ber_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q    <= '0;
            data_q   <= '0;
            state_q  <= BER_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            hi_ber_q <= 1'b0;
            status_q <= 1'b0;
        end else begin
            hdr_q    <= i_serdes_rx_hdr;
            data_q   <= descr_data;
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            hi_ber_q <= hi_ber_d;
            status_q <= status_d;
        end
    end

    assign o_rx_hdr      = hdr_q;
    assign o_rx_data     = data_q;
    assign o_rx_high_ber = hi_ber_q;
    assign o_rx_status   = status_q;

endmodule
